// File: rtl/cipher_pkg.sv
// Shared types and width-agnostic helpers for the cipher_pipe datapath.
// Helpers work on MAX_N-bit words and take the active width n as an argument.
package cipher_pkg;

  typedef enum logic {MODE_ENC = 1'b0, MODE_DEC = 1'b1} cipher_mode_t;

  localparam int MAX_N = 128;
  typedef logic [MAX_N-1:0] word_t;

  function automatic word_t width_mask(input int n);
    return {MAX_N{1'b1}} >> (MAX_N - n);
  endfunction

  function automatic word_t swap_halves(input word_t y, input int n);
    word_t v;
    v = y & width_mask(n);
    return ((v >> (n / 2)) | (v << (n / 2))) & width_mask(n);
  endfunction

  // Reverse the full word, then shift the reversed n-bit field back down to bit 0.
  function automatic word_t bit_reverse(input word_t y, input int n);
    word_t v;
    word_t r;
    v = y & width_mask(n);
    r = {<<{v}};
    return r >> (MAX_N - n);
  endfunction

  function automatic word_t core_t(input word_t y, input int n);
    return swap_halves(bit_reverse(~swap_halves(y, n) & width_mask(n), n), n);
  endfunction

  function automatic word_t round_key(input word_t key, input int r, input int n);
    int    s;
    word_t k;
    s = r % n;
    k = key & width_mask(n);
    return ((k << s) | (k >> (n - s))) & width_mask(n);
  endfunction

endpackage

// File: rtl/cipher_round.sv
// One pipeline stage: applies the encrypt or decrypt round selected by the
// travelling mode bit and registers the word together with its key and mode.
module cipher_round
  import cipher_pkg::*;
#(
  parameter int N      = 32,
  parameter int R_IDX  = 0,
  parameter int ROUNDS = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic         in_valid,
  input  cipher_mode_t in_mode,
  input  logic [N-1:0] in_key,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  output cipher_mode_t out_mode,
  output logic [N-1:0] out_key,
  output logic [N-1:0] out_data
);

  typedef struct packed {
    logic         valid;
    cipher_mode_t mode;
    logic [N-1:0] key;
    logic [N-1:0] data;
  } stage_t;

  localparam int ENC_R = R_IDX;
  localparam int DEC_R = ROUNDS - 1 - R_IDX;

  stage_t       stage_q, stage_d;
  logic [N-1:0] k_enc, k_dec, enc_word, dec_word;

  always_comb begin
    k_enc    = N'(round_key(word_t'(in_key), ENC_R, N));
    k_dec    = N'(round_key(word_t'(in_key), DEC_R, N));
    enc_word = N'(core_t(word_t'(in_data ^ k_enc), N));
    dec_word = N'(core_t(word_t'(in_data), N)) ^ k_dec;

    stage_d = stage_q;
    // Bubbles load all-zero so an idle output reads back as 0.
    if (en) begin
      stage_d = '0;
      if (in_valid) begin
        stage_d.valid = 1'b1;
        stage_d.mode  = in_mode;
        stage_d.key   = in_key;
        stage_d.data  = (in_mode == MODE_DEC) ? dec_word : enc_word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) stage_q <= '0;
    else          stage_q <= stage_d;
  end

  assign out_valid = stage_q.valid;
  assign out_mode  = stage_q.mode;
  assign out_key   = stage_q.key;
  assign out_data  = stage_q.data;

endmodule

// File: rtl/cipher_pipe.sv
// ROUNDS-stage encrypt/decrypt pipeline with a single global advance enable.
// Define CIPHER_PIPE_STATS_EN to add per-mode output handshake counters.
module cipher_pipe
  import cipher_pkg::*;
#(
  parameter int N      = 32,
  parameter int ROUNDS = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_key,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [N-1:0] out_data
`ifdef CIPHER_PIPE_STATS_EN
  ,
  output logic [15:0]  enc_count,
  output logic [15:0]  dec_count
`endif
);

  logic         stg_valid [ROUNDS+1];
  cipher_mode_t stg_mode  [ROUNDS+1];
  logic [N-1:0] stg_key   [ROUNDS+1];
  logic [N-1:0] stg_data  [ROUNDS+1];
  logic         adv;

  // All stages move together, so only a stalled output word can block the pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign stg_valid[0] = in_valid;
  assign stg_mode[0]  = cipher_mode_t'(in_mode);
  assign stg_key[0]   = in_key;
  assign stg_data[0]  = in_data;

  generate
    for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_round
      cipher_round #(
        .N      (N),
        .R_IDX  (gi),
        .ROUNDS (ROUNDS)
      ) u_round (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (adv),
        .in_valid  (stg_valid[gi]),
        .in_mode   (stg_mode[gi]),
        .in_key    (stg_key[gi]),
        .in_data   (stg_data[gi]),
        .out_valid (stg_valid[gi+1]),
        .out_mode  (stg_mode[gi+1]),
        .out_key   (stg_key[gi+1]),
        .out_data  (stg_data[gi+1])
      );
    end
  endgenerate

  assign out_valid = stg_valid[ROUNDS];
  assign out_mode  = stg_mode[ROUNDS];
  assign out_data  = stg_data[ROUNDS];

`ifdef CIPHER_PIPE_STATS_EN
  logic [15:0] enc_count_q, enc_count_d;
  logic [15:0] dec_count_q, dec_count_d;

  always_comb begin
    enc_count_d = enc_count_q;
    dec_count_d = dec_count_q;
    if (out_valid && out_ready) begin
      if (stg_mode[ROUNDS] == MODE_DEC) dec_count_d = dec_count_q + 16'd1;
      else                              enc_count_d = enc_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      enc_count_q <= '0;
      dec_count_q <= '0;
    end else begin
      enc_count_q <= enc_count_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign enc_count = enc_count_q;
  assign dec_count = dec_count_q;
`endif

endmodule

// File: tb/tb_cipher_pipe.sv
// Directed bench for cipher_pipe: N=8 single/two-round vectors, N=32 streaming
// with backpressure, round trip and mid-stream reset (counters if CIPHER_PIPE_STATS_EN).
module tb_cipher_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Shared N=8 stimulus for the ROUNDS=1 and ROUNDS=2 instances
  logic       in8_valid, in8_mode, out8_ready;
  logic [7:0] in8_key, in8_data;
  logic       r1_in_ready, r1_out_valid, r1_out_mode;
  logic [7:0] r1_out_data;
  logic       r2_in_ready, r2_out_valid, r2_out_mode;
  logic [7:0] r2_out_data;

  logic        d4_in_valid, d4_in_ready, d4_in_mode, d4_out_valid, d4_out_ready, d4_out_mode;
  logic [31:0] d4_in_key, d4_in_data, d4_out_data;

`ifdef CIPHER_PIPE_STATS_EN
  logic [15:0] r1_enc, r1_dec, r2_enc, r2_dec, d4_enc, d4_dec;
`endif

  cipher_pipe #(.N(8), .ROUNDS(1)) u_r1 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in8_valid), .in_ready(r1_in_ready), .in_mode(in8_mode),
    .in_key(in8_key), .in_data(in8_data),
    .out_valid(r1_out_valid), .out_ready(out8_ready), .out_mode(r1_out_mode),
    .out_data(r1_out_data)
`ifdef CIPHER_PIPE_STATS_EN
    , .enc_count(r1_enc), .dec_count(r1_dec)
`endif
  );

  cipher_pipe #(.N(8), .ROUNDS(2)) u_r2 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in8_valid), .in_ready(r2_in_ready), .in_mode(in8_mode),
    .in_key(in8_key), .in_data(in8_data),
    .out_valid(r2_out_valid), .out_ready(out8_ready), .out_mode(r2_out_mode),
    .out_data(r2_out_data)
`ifdef CIPHER_PIPE_STATS_EN
    , .enc_count(r2_enc), .dec_count(r2_dec)
`endif
  );

  cipher_pipe #(.N(32), .ROUNDS(4)) u_d4 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_mode(d4_in_mode),
    .in_key(d4_in_key), .in_data(d4_in_data),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_mode(d4_out_mode),
    .out_data(d4_out_data)
`ifdef CIPHER_PIPE_STATS_EN
    , .enc_count(d4_enc), .dec_count(d4_dec)
`endif
  );

  // Reference model for N=32, ROUNDS=4, written bit by bit
  function automatic logic [31:0] m_t(input logic [31:0] y);
    logic [31:0] a, b;
    a = ~{y[15:0], y[31:16]};
    for (int i = 0; i < 32; i++) b[i] = a[31-i];
    return {b[15:0], b[31:16]};
  endfunction

  function automatic logic [31:0] m_rk(input logic [31:0] k, input int r);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[(i + r) % 32] = k[i];
    return o;
  endfunction

  function automatic logic [31:0] m_cipher(input logic mode, input logic [31:0] k, input logic [31:0] d);
    logic [31:0] x;
    x = d;
    for (int j = 0; j < 4; j++) begin
      if (mode) x = m_t(x) ^ m_rk(k, 3 - j);
      else      x = m_t(x ^ m_rk(k, j));
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic        w_mode [100];
  logic [31:0] w_key  [100];
  logic [31:0] w_data [100];
  logic [31:0] w_exp  [100];
  logic [31:0] w_got  [100];
  logic [31:0] pt     [64];
  int          n_enc;

  // Cycle-stepped stream through u_d4; entered and left at a falling edge.
  task automatic run_stream(input int n, input bit bp);
    int          sent, rcv, cyc;
    bit          stall_prev;
    logic [31:0] data_prev;
    logic        mode_prev;
    sent = 0; rcv = 0; cyc = 0; stall_prev = 1'b0; data_prev = '0; mode_prev = 1'b0;
    while (rcv < n && cyc < 20 * n + 100) begin
      if (stall_prev) begin
        check("stall_valid", 32'(d4_out_valid), 32'd1);
        check("stall_data", d4_out_data, data_prev);
        check("stall_mode", 32'(d4_out_mode), 32'(mode_prev));
      end
      d4_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n && (!bp || $urandom_range(0, 3) != 0)) begin
        d4_in_valid = 1'b1;
        d4_in_mode  = w_mode[sent];
        d4_in_key   = w_key[sent];
        d4_in_data  = w_data[sent];
      end else begin
        d4_in_valid = 1'b0;
        d4_in_data  = $urandom;
      end
      #1;
      check("in_ready", 32'(d4_in_ready), 32'(!(d4_out_valid && !d4_out_ready)));
      if (d4_in_valid && d4_in_ready) sent++;
      if (d4_out_valid && d4_out_ready) begin
        check("stream_data", d4_out_data, w_exp[rcv]);
        check("stream_mode", 32'(d4_out_mode), 32'(w_mode[rcv]));
        w_got[rcv] = d4_out_data;
        rcv++;
      end
      stall_prev = d4_out_valid && !d4_out_ready;
      data_prev  = d4_out_data;
      mode_prev  = d4_out_mode;
      cyc++;
      @(negedge clk);
    end
    check("stream_count", 32'(rcv), 32'(n));
    d4_in_valid  = 1'b0;
    d4_out_ready = 1'b1;
  endtask

  task automatic drive8(input logic v, input logic m, input logic [7:0] k, input logic [7:0] d);
    in8_valid = v; in8_mode = m; in8_key = k; in8_data = d;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    in8_valid = 1'b0; in8_mode = 1'b0; in8_key = '0; in8_data = '0; out8_ready = 1'b1;
    d4_in_valid = 1'b0; d4_in_mode = 1'b0; d4_in_key = '0; d4_in_data = '0; d4_out_ready = 1'b1;

    // Reset state and idle after release
    @(negedge clk);
    check("rst_valid", 32'(r1_out_valid), 32'd0);
    check("rst_data", 32'(r1_out_data), 32'd0);
    check("rst_mode", 32'(r1_out_mode), 32'd0);
    check("rst_in_ready", 32'(r1_in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_valid_r1", 32'(r1_out_valid), 32'd0);
      check("idle_data_r1", 32'(r1_out_data), 32'd0);
      check("idle_ready_r1", 32'(r1_in_ready), 32'd1);
      check("idle_valid_d4", 32'(d4_out_valid), 32'd0);
      check("idle_data_d4", d4_out_data, 32'd0);
      check("idle_ready_d4", 32'(d4_in_ready), 32'd1);
    end

    // Single round (ROUNDS=1)
    drive8(1'b1, 1'b0, 8'h00, 8'h00);
    check("r1_enc00_valid", 32'(r1_out_valid), 32'd1);
    check("r1_enc00_data", 32'(r1_out_data), 32'h0000_00FF);
    drive8(1'b1, 1'b0, 8'h0F, 8'h00);
    check("r1_enc0f_data", 32'(r1_out_data), 32'h0000_000F);
    check("r1_enc0f_mode", 32'(r1_out_mode), 32'd0);
    drive8(1'b1, 1'b1, 8'h0F, 8'h0F);
    check("r1_dec0f_data", 32'(r1_out_data), 32'h0000_0000);
    check("r1_dec0f_mode", 32'(r1_out_mode), 32'd1);

    // Two rounds (ROUNDS=2): result appears one edge after the following input
    drive8(1'b1, 1'b0, 8'h01, 8'h00);
    drive8(1'b1, 1'b1, 8'h01, 8'h41);
    check("r2_enc_valid", 32'(r2_out_valid), 32'd1);
    check("r2_enc_data", 32'(r2_out_data), 32'h0000_0041);
    check("r2_enc_mode", 32'(r2_out_mode), 32'd0);
    drive8(1'b0, 1'b0, 8'h00, 8'h00);
    check("r2_dec_data", 32'(r2_out_data), 32'h0000_0000);
    check("r2_dec_mode", 32'(r2_out_mode), 32'd1);
    @(negedge clk);
    check("r2_bubble_valid", 32'(r2_out_valid), 32'd0);
    check("r2_bubble_data", 32'(r2_out_data), 32'd0);

    // Backpressure on ROUNDS=2: stall holds output, blocks input, no drop/dup
    out8_ready = 1'b0;
    drive8(1'b1, 1'b0, 8'h01, 8'h00);
    drive8(1'b1, 1'b1, 8'h01, 8'h41);
    check("r2_stall_ready", 32'(r2_in_ready), 32'd0);
    check("r2_stall_valid", 32'(r2_out_valid), 32'd1);
    check("r2_stall_data", 32'(r2_out_data), 32'h0000_0041);
    drive8(1'b1, 1'b0, 8'h00, 8'h00);
    check("r2_hold_data", 32'(r2_out_data), 32'h0000_0041);
    check("r2_hold_ready", 32'(r2_in_ready), 32'd0);
    out8_ready = 1'b1;
    drive8(1'b0, 1'b0, 8'h00, 8'h00);
    check("r2_next_valid", 32'(r2_out_valid), 32'd1);
    check("r2_next_data", 32'(r2_out_data), 32'h0000_0000);
    check("r2_next_mode", 32'(r2_out_mode), 32'd1);
    @(negedge clk);
    check("r2_no_extra", 32'(r2_out_valid), 32'd0);

    // N=32 streaming with random backpressure and interleaved modes
    n_enc = 0;
    for (int i = 0; i < 100; i++) begin
      w_mode[i] = 1'($urandom_range(0, 1));
      w_key[i]  = $urandom;
      w_data[i] = $urandom;
      w_exp[i]  = m_cipher(w_mode[i], w_key[i], w_data[i]);
      if (!w_mode[i]) n_enc++;
    end
    run_stream(100, 1'b1);

    // Round trip: encrypt, then decrypt the ciphertexts with the same keys
    for (int i = 0; i < 64; i++) begin
      w_mode[i] = 1'b0;
      w_key[i]  = $urandom;
      w_data[i] = $urandom;
      pt[i]     = w_data[i];
      w_exp[i]  = m_cipher(1'b0, w_key[i], w_data[i]);
    end
    run_stream(64, 1'b0);
    for (int i = 0; i < 64; i++) begin
      w_mode[i] = 1'b1;
      w_data[i] = w_got[i];
      w_exp[i]  = pt[i];
    end
    run_stream(64, 1'b1);

`ifdef CIPHER_PIPE_STATS_EN
    check("enc_count", 32'(d4_enc), 32'(n_enc + 64));
    check("dec_count", 32'(d4_dec), 32'(100 - n_enc + 64));
`endif

    // Reset with three words in flight
    for (int i = 0; i < 3; i++) begin
      d4_in_valid = 1'b1; d4_in_mode = w_mode[i]; d4_in_key = w_key[i]; d4_in_data = w_data[i];
      @(negedge clk);
    end
    d4_in_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_valid", 32'(d4_out_valid), 32'd0);
      check("flush_data", d4_out_data, 32'd0);
    end
`ifdef CIPHER_PIPE_STATS_EN
    check("flush_enc_count", 32'(d4_enc), 32'd0);
    check("flush_dec_count", 32'(d4_dec), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
